// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants, FSM state type and leading-zero blanking helper
package fnd_pkg;
   localparam int BCD_W = 4;
   localparam int DIGITS = 4;
   localparam logic [BCD_W-1:0] FND_BLANK = 4'hF;
   localparam int FND_MAX = 9999;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   // Units digit is never blanked; blanking stops at the first nonzero digit
   function automatic logic [15:0] fnd_blank(input logic [15:0] d);
      logic b3, b2, b1;
      b3 = d[15:12] == 4'd0;
      b2 = b3 && d[11:8] == 4'd0;
      b1 = b2 && d[7:4] == 4'd0;
      return {b3 ? FND_BLANK : d[15:12], b2 ? FND_BLANK : d[11:8], b1 ? FND_BLANK : d[7:4], d[3:0]};
   endfunction
endpackage

// File: rtl/fnd_bin2bcd_seq_if.sv
// fnd_bin2bcd_seq_if: start/value request and digit/status response of the BCD converter
interface fnd_bin2bcd_seq_if
   import fnd_pkg::*;
#(parameter int IN_W = 14);
   logic i_start;
   logic [IN_W-1:0] i_value;
   logic o_busy, o_done, o_ovf;
   logic [BCD_W-1:0] o_1000, o_100, o_10, o_1;
   modport master(output i_start, i_value, input o_busy, o_done, o_ovf, o_1000, o_100, o_10, o_1);
   modport slave(input i_start, i_value, output o_busy, o_done, o_ovf, o_1000, o_100, o_10, o_1);
endinterface

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 to any nibble of 5 or more
module bcd_add3 (
   input  logic [3:0] in_i,
   output logic [3:0] out_o
);
   assign out_o = in_i >= 4'd5 ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/fnd_bin2bcd_seq.sv
// fnd_bin2bcd_seq: one-bit-per-cycle double-dabble binary to 4-digit BCD converter
// Define FND_LEADING_BLANK_EN to replace leading zero digits with 4'hF when latched.
module fnd_bin2bcd_seq
   import fnd_pkg::*;
#(
   parameter int IN_W = 14,
   parameter int MAX_VAL = FND_MAX
) (
   input logic clk,
   input logic reset,
   fnd_bin2bcd_seq_if.slave bus
);
   state_t state_q, state_d;
   logic [IN_W-1:0] bin_q, bin_d, sat;
   logic [IN_W+15:0] cat;
   logic [15:0] scr_q, scr_d, adj, dig_q, dig_d, latch;
   logic [4:0] cnt_q, cnt_d;
   logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, over, start_ok, shifting, last;
   genvar i;
   for (i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (.in_i(scr_q[i*BCD_W+:BCD_W]), .out_o(adj[i*BCD_W+:BCD_W]));
   end
   always_comb begin
      shifting = state_q == SHIFT;
      start_ok = bus.i_start && !shifting;
      last = shifting && cnt_q == 5'd0;
      over = bus.i_value > IN_W'(MAX_VAL);
      sat = over ? IN_W'(MAX_VAL) : bus.i_value;
      cat = {adj, bin_q} << 1;
`ifdef FND_LEADING_BLANK_EN
      latch = fnd_blank(cat[IN_W+15:IN_W]);
`else
      latch = cat[IN_W+15:IN_W];
`endif
      state_d = start_ok ? SHIFT : shifting ? (last ? DONE : SHIFT) : IDLE;
      bin_d = start_ok ? sat : shifting ? cat[IN_W-1:0] : bin_q;
      scr_d = start_ok ? 16'd0 : shifting ? cat[IN_W+15:IN_W] : scr_q;
      cnt_d = start_ok ? 5'(IN_W-1) : shifting ? cnt_q - 5'd1 : cnt_q;
      busy_d = start_ok || (busy_q && !last);
      done_d = last;
      ovf_d = start_ok ? over : ovf_q;
      dig_d = last ? latch : dig_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q <= '0;
         scr_q <= '0;
         cnt_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q <= 1'b0;
         dig_q <= '0;
      end else begin
         state_q <= state_d;
         bin_q <= bin_d;
         scr_q <= scr_d;
         cnt_q <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         ovf_q <= ovf_d;
         dig_q <= dig_d;
      end
   end
   assign bus.o_busy = busy_q;
   assign bus.o_done = done_q;
   assign bus.o_ovf = ovf_q;
   assign {bus.o_1000, bus.o_100, bus.o_10, bus.o_1} = dig_q;
endmodule

// File: tb/tb_fnd_bin2bcd_seq.sv
// tb_fnd_bin2bcd_seq: scoreboard bench with a decimal-arithmetic reference model
module tb_fnd_bin2bcd_seq;
   typedef struct packed {
      logic [15:0] dig;
      logic ovf;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   exp_t q[$];
   exp_t e;
   logic done_prev = 1'b0;
   logic [15:0] dig;
   logic [15:0] last_dig = 16'd0;
   int n;
   always #5 clk = ~clk;
   fnd_bin2bcd_seq_if #(.IN_W(14)) bus ();
   fnd_bin2bcd_seq #(.IN_W(14), .MAX_VAL(9999)) dut (.clk(clk), .reset(reset), .bus(bus));
   assign dig = {bus.o_1000, bus.o_100, bus.o_10, bus.o_1};

   function automatic exp_t model(input int v);
      int s;
      int d[4];
      exp_t r;
      s = v > 9999 ? 9999 : v;
      d[3] = s / 1000;
      d[2] = (s / 100) % 10;
      d[1] = (s / 10) % 10;
      d[0] = s % 10;
`ifdef FND_LEADING_BLANK_EN
      for (int k = 3; k > 0 && d[k] == 0; k--) d[k] = 15;
`endif
      r.dig = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
      r.ovf = v > 9999;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Call at a negedge or just after a posedge; returns just after the accepting edge
   task automatic do_start(input int v);
      bus.i_start = 1'b1;
      bus.i_value = 14'(v);
      q.push_back(model(v));
      @(posedge clk);
      #1 bus.i_start = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      logic busy_ok;
      busy_ok = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (!bus.o_done && !bus.o_busy) busy_ok = 1'b0;
      end while (!bus.o_done && cnt < 50);
      chk("done_seen", {31'd0, bus.o_done}, 32'd1);
      chk("busy_during_conv", {31'd0, busy_ok}, 32'd1);
      chk("busy_low_at_done", {31'd0, bus.o_busy}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (bus.o_done) begin
         checks++;
         if (done_prev) begin
            errors++;
            $display("FAIL done_pulse: o_done high for two cycles, digits %h", dig);
         end else if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got digits %h with nothing pending", dig);
         end else begin
            e = q.pop_front();
            if (dig !== e.dig || bus.o_ovf !== e.ovf) begin
               errors++;
               $display("FAIL result: got digits %h ovf %b expected digits %h ovf %b", dig, bus.o_ovf, e.dig, e.ovf);
            end
            last_dig = e.dig;
         end
      end
      done_prev = bus.o_done;
   end

   initial begin
      bus.i_start = 1'b0;
      bus.i_value = '0;
      #1 chk("reset_state", {16'd0, dig, bus.o_busy, bus.o_done, bus.o_ovf}, 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_release", {16'd0, dig, bus.o_busy, bus.o_done, bus.o_ovf}, 32'd0);
      do_start(1234);
      wait_done(n);
      chk("latency_1234", n, 32'd15);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, bus.o_done}, 32'd0);
      do_start(0);
      wait_done(n);
      @(negedge clk);
      do_start(9999);
      wait_done(n);
      @(negedge clk);
      do_start(12000);
      wait_done(n);
      repeat (3) @(negedge clk);
      chk("ovf_hold_idle", {15'd0, bus.o_ovf, dig}, {15'd0, 1'b1, model(9999).dig});
      do_start(7);
      wait_done(n);
      @(negedge clk);
      do_start(1005);
      wait_done(n);
      @(negedge clk);
      do_start(1234);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_value = 14'd5678;
      @(posedge clk);
      #1 bus.i_start = 1'b0;
      wait_done(n);
      chk("latency_ignored_start", n, 32'd10);
      do_start(5678);
      wait_done(n);
      chk("latency_back_to_back", n, 32'd15);
      @(negedge clk);
      do_start(4321);
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      void'(q.pop_back());
      #1 chk("async_reset", {16'd0, dig, bus.o_busy, bus.o_done, bus.o_ovf}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", {15'd0, bus.o_busy, dig}, 32'd0);
      do_start(4321);
      wait_done(n);
      chk("latency_after_abort", n, 32'd15);
      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_start(($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999)));
         wait_done(n);
      end
      repeat (4) @(negedge clk);
      chk("digits_hold_idle", {16'd0, dig}, {16'd0, last_dig});
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
